// File: rtl/ram_arb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : ram_arb_pkg                                                      |
// | Brief   : Shared state encoding and master ids for the RAM port arbiter.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package ram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } arb_state_t;

    localparam logic M0 = 1'b0;
    localparam logic M1 = 1'b1;

endpackage
`default_nettype wire

// File: rtl/ram_arb_fsm.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : ram_arb_fsm                                                      |
// | Brief   : Round-robin ownership FSM with bounded burst; combinational grant.|
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module ram_arb_fsm
    import ram_arb_pkg::*;
#(
    parameter int MAX_BURST = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic i_m0_req,
    input  logic i_m1_req,
    output logic o_gnt_valid,
    output logic o_gnt_id
);

    localparam int c_cnt_w = $clog2(MAX_BURST + 1);
    localparam logic [c_cnt_w-1:0] c_max = c_cnt_w'(MAX_BURST);

    arb_state_t         r_state;
    logic               r_last;
    logic [c_cnt_w-1:0] r_beat_cnt;
    logic               w_owner;
    logic               w_owner_req;
    logic               w_other_req;

    always_comb begin
        o_gnt_valid = 1'b0;
        o_gnt_id    = M0;
        w_owner     = (r_state == OWN1) ? M1 : M0;
        w_owner_req = (w_owner == M1) ? i_m1_req : i_m0_req;
        w_other_req = (w_owner == M1) ? i_m0_req : i_m1_req;
        if (!rst) begin
            if (r_state == IDLE) begin
                if (i_m0_req && i_m1_req) begin
                    o_gnt_valid = 1'b1;
                    o_gnt_id    = ~r_last;
                end else if (i_m0_req || i_m1_req) begin
                    o_gnt_valid = 1'b1;
                    o_gnt_id    = i_m0_req ? M0 : M1;
                end
            end else if (w_owner_req && ((r_beat_cnt < c_max) || !w_other_req)) begin
                o_gnt_valid = 1'b1;
                o_gnt_id    = w_owner;
            end else if (w_other_req) begin
                // Hand over in the same cycle so a yield costs no bubble.
                o_gnt_valid = 1'b1;
                o_gnt_id    = ~w_owner;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_last     <= M1;
            r_beat_cnt <= '0;
        end else if (o_gnt_valid) begin
            r_state <= (o_gnt_id == M1) ? OWN1 : OWN0;
            r_last  <= o_gnt_id;
            if ((r_state == IDLE) || (o_gnt_id != w_owner)) begin
                r_beat_cnt <= c_cnt_w'(1);
            end else if (r_beat_cnt < c_max) begin
                r_beat_cnt <= r_beat_cnt + 1'b1;
            end
        end else begin
            r_state    <= IDLE;
            r_beat_cnt <= '0;
        end
    end

endmodule
`default_nettype wire

// File: rtl/ram_port_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : ram_port_arbiter                                                 |
// | Brief   : Shares one single-port RAM between fetch (m0) and load/store (m1).|
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module ram_port_arbiter
    import ram_arb_pkg::*;
#(
    parameter int BUS_WIDTH = 14,
    parameter int MAX_BURST = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 m0_req,
    input  logic                 m0_we,
    input  logic [BUS_WIDTH-1:0] m0_addr,
    input  logic [31:0]          m0_wdata,
    output logic                 m0_ready,
    output logic                 m0_rvalid,
    output logic [31:0]          m0_rdata,
    input  logic                 m1_req,
    input  logic                 m1_we,
    input  logic [BUS_WIDTH-1:0] m1_addr,
    input  logic [31:0]          m1_wdata,
    output logic                 m1_ready,
    output logic                 m1_rvalid,
    output logic [31:0]          m1_rdata,
    output logic [BUS_WIDTH-1:0] ram_addr,
    output logic [31:0]          ram_dataIn,
    output logic                 ram_wrEnable,
    input  logic [31:0]          ram_dataOut
);

    logic w_gnt_valid;
    logic w_gnt_id;
    logic r_rvalid;
    logic r_rid;

    ram_arb_fsm #(
        .MAX_BURST (MAX_BURST)
    ) u_fsm (
        .clk         (clk),
        .rst         (rst),
        .i_m0_req    (m0_req),
        .i_m1_req    (m1_req),
        .o_gnt_valid (w_gnt_valid),
        .o_gnt_id    (w_gnt_id)
    );

    // Idle cycles present an all-zero read so the RAM sees a harmless dummy access.
    always_comb begin
        ram_addr     = '0;
        ram_dataIn   = '0;
        ram_wrEnable = 1'b0;
        if (w_gnt_valid) begin
            if (w_gnt_id == M1) begin
                ram_addr     = m1_addr;
                ram_dataIn   = m1_wdata;
                ram_wrEnable = m1_we;
            end else begin
                ram_addr     = m0_addr;
                ram_dataIn   = m0_wdata;
                ram_wrEnable = m0_we;
            end
        end
    end

    assign m0_ready = w_gnt_valid && (w_gnt_id == M0);
    assign m1_ready = w_gnt_valid && (w_gnt_id == M1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rvalid <= 1'b0;
            r_rid    <= M0;
        end else begin
            r_rvalid <= w_gnt_valid && !ram_wrEnable;
            r_rid    <= w_gnt_id;
        end
    end

    assign m0_rvalid = r_rvalid && (r_rid == M0);
    assign m1_rvalid = r_rvalid && (r_rid == M1);
    assign m0_rdata  = ram_dataOut;
    assign m1_rdata  = ram_dataOut;

endmodule
`default_nettype wire

// File: tb/tb_ram_port_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_ram_port_arbiter                                              |
// | Brief   : Directed and random checks of ram_port_arbiter against a model.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_ram_port_arbiter;

    localparam int BW = 14;
    localparam int MB = 4;

    logic          clk;
    logic          rst;
    logic          req0, we0, req1, we1;
    logic [BW-1:0] addr0, addr1;
    logic [31:0]   wd0, wd1;
    logic          rdy0, rdy1, rv0, rv1;
    logic [31:0]   rd0, rd1;
    logic [BW-1:0] ram_addr;
    logic [31:0]   ram_din;
    logic          ram_we;
    logic [31:0]   ram_dout;

    logic [31:0] mem    [0:(1<<BW)-1];
    logic [31:0] shadow [0:(1<<BW)-1];

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: who held the RAM last cycle and for how many beats in a row.
    bit          m_own_v;
    bit          m_owner;
    int          m_streak;
    bit          m_last;
    bit          m_pend;
    bit          m_pend_id;
    logic [31:0] m_pend_data;
    bit          g_v, g_id;
    logic        a_r0, a_r1, a_rv0, a_rv1;
    logic [31:0] a_rd0, a_rd1;
    bit          pend0, pend1;

    ram_port_arbiter #(.BUS_WIDTH(BW), .MAX_BURST(MB)) dut (
        .clk(clk), .rst(rst),
        .m0_req(req0), .m0_we(we0), .m0_addr(addr0), .m0_wdata(wd0),
        .m0_ready(rdy0), .m0_rvalid(rv0), .m0_rdata(rd0),
        .m1_req(req1), .m1_we(we1), .m1_addr(addr1), .m1_wdata(wd1),
        .m1_ready(rdy1), .m1_rvalid(rv1), .m1_rdata(rd1),
        .ram_addr(ram_addr), .ram_dataIn(ram_din), .ram_wrEnable(ram_we),
        .ram_dataOut(ram_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_din;
        ram_dout <= mem[ram_addr];
    end

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %h expected %h", tag, $time, act, exp);
        end
    endtask

    // One clock: predict and compare at negedge, advance the model at posedge.
    task automatic step();
        bit          oreq, xreq;
        logic [BW-1:0] e_addr;
        logic [31:0] e_din;
        bit          e_we;
        @(negedge clk);
        g_v = 0; g_id = 0;
        if (!rst) begin
            if (!m_own_v) begin
                if (req0 && req1) begin g_v = 1; g_id = !m_last; end
                else if (req0)    begin g_v = 1; g_id = 0; end
                else if (req1)    begin g_v = 1; g_id = 1; end
            end else begin
                oreq = m_owner ? req1 : req0;
                xreq = m_owner ? req0 : req1;
                if (oreq && (m_streak < MB || !xreq)) begin g_v = 1; g_id = m_owner; end
                else if (xreq) begin g_v = 1; g_id = !m_owner; end
            end
        end
        e_addr = g_v ? (g_id ? addr1 : addr0) : '0;
        e_din  = g_v ? (g_id ? wd1 : wd0) : '0;
        e_we   = g_v ? (g_id ? we1 : we0) : 1'b0;
        a_r0 = rdy0; a_r1 = rdy1; a_rv0 = rv0; a_rv1 = rv1; a_rd0 = rd0; a_rd1 = rd1;
        check_val("m0_ready", 32'(rdy0), 32'(g_v && !g_id));
        check_val("m1_ready", 32'(rdy1), 32'(g_v && g_id));
        check_val("ram_we", 32'(ram_we), 32'(e_we));
        check_val("ram_addr", 32'(ram_addr), 32'(e_addr));
        check_val("ram_din", ram_din, e_din);
        check_val("m0_rvalid", 32'(rv0), 32'(m_pend && !m_pend_id));
        check_val("m1_rvalid", 32'(rv1), 32'(m_pend && m_pend_id));
        if (m_pend) check_val("rdata", m_pend_id ? rd1 : rd0, m_pend_data);
        @(posedge clk);
        m_pend = 0;
        if (rst) begin
            m_own_v = 0; m_last = 1; m_streak = 0;
        end else if (g_v) begin
            m_streak = (m_own_v && m_owner == g_id) ? m_streak + 1 : 1;
            m_own_v  = 1; m_owner = g_id; m_last = g_id;
            if (e_we) shadow[e_addr] = e_din;
            else begin m_pend = 1; m_pend_id = g_id; m_pend_data = shadow[e_addr]; end
        end else begin
            m_own_v = 0; m_streak = 0;
        end
        #1;
    endtask

    task automatic set_m0(input bit r, input bit w, input logic [BW-1:0] a, input logic [31:0] d);
        req0 = r; we0 = w; addr0 = a; wd0 = d;
    endtask

    task automatic set_m1(input bit r, input bit w, input logic [BW-1:0] a, input logic [31:0] d);
        req1 = r; we1 = w; addr1 = a; wd1 = d;
    endtask

    task automatic do_reset();
        rst = 1; step(); rst = 0;
    endtask

    function automatic logic [BW-1:0] pick_addr();
        logic [BW-1:0] base;
        base = $urandom_range(0, 1) ? 14'h3FF8 : 14'h0000;
        return base + BW'($urandom_range(0, 7));
    endfunction

    initial begin
        for (int i = 0; i < (1 << BW); i++) begin mem[i] = '0; shadow[i] = '0; end
        ram_dout = '0;
        m_own_v = 0; m_owner = 0; m_streak = 0; m_last = 1; m_pend = 0; m_pend_id = 0; m_pend_data = '0;
        rst = 1;
        set_m0(1, 0, '0, '0);
        set_m1(1, 0, '0, '0);

        // Reset held two cycles with both requesting, then m0 wins the first tie.
        step();
        check_val("rst_ready", 32'({a_r0, a_r1, a_rv0, a_rv1}), 32'd0);
        step();
        rst = 0;
        step();
        check_val("first_m0", 32'(a_r0), 32'd1);

        // Write then read-after-write on m0.
        do_reset();
        set_m1(0, 0, '0, '0);
        set_m0(1, 1, 14'h0010, 32'hDEADBEEF); step();
        set_m0(1, 0, 14'h0010, 32'h0);        step();
        set_m0(0, 0, '0, '0);                 step();
        check_val("raw_rvalid", 32'(a_rv0), 32'd1);
        check_val("raw_rdata", a_rd0, 32'hDEADBEEF);

        // Continuous contention: 4 beats each, alternating, no idle cycles.
        do_reset();
        set_m0(1, 0, 14'h0001, '0);
        set_m1(1, 0, 14'h0002, '0);
        for (int i = 0; i < 12; i++) begin
            step();
            check_val("burst_gnt", 32'({a_r1, a_r0}), ((i / 4) % 2) ? 32'd2 : 32'd1);
        end

        // Owner drops early: m1 takes over at once with a fresh burst count.
        do_reset();
        step(); step();
        req0 = 0; step();
        check_val("handover", 32'(a_r1), 32'd1);
        req0 = 1;
        for (int i = 0; i < 3; i++) begin step(); check_val("m1_cont", 32'(a_r1), 32'd1); end
        step();
        check_val("m0_back", 32'(a_r0), 32'd1);

        // Top address on m1 only.
        set_m0(0, 0, '0, '0);
        set_m1(1, 1, 14'h3FFF, 32'h12345678); step();
        set_m1(1, 0, 14'h3FFF, 32'h0);        step();
        set_m1(0, 0, '0, '0);                 step();
        check_val("top_rv1", 32'(a_rv1), 32'd1);
        check_val("top_rv0", 32'(a_rv0), 32'd0);
        check_val("top_rdata", a_rd1, 32'h12345678);

        // Reset in the cycle of a read: nothing returns, m0 wins the restart.
        set_m0(1, 0, 14'h0010, '0);
        rst = 1; step();
        check_val("rst_noacc", 32'(a_r0), 32'd0);
        rst = 0;
        set_m1(1, 0, 14'h0020, '0);
        step();
        check_val("rst_norv", 32'({a_rv0, a_rv1}), 32'd0);
        check_val("rst_m0", 32'(a_r0), 32'd1);

        // Random traffic, occasional resets; masters hold a beat until accepted.
        set_m0(0, 0, '0, '0);
        set_m1(0, 0, '0, '0);
        pend0 = 0; pend1 = 0;
        for (int c = 0; c < 1000; c++) begin
            rst = ($urandom_range(0, 79) == 0);
            if (!pend0 && $urandom_range(0, 3) != 0) begin
                pend0 = 1; we0 = $urandom_range(0, 1); addr0 = pick_addr(); wd0 = $urandom;
            end
            if (!pend1 && $urandom_range(0, 3) != 0) begin
                pend1 = 1; we1 = $urandom_range(0, 1); addr1 = pick_addr(); wd1 = $urandom;
            end
            req0 = pend0; req1 = pend1;
            step();
            if (g_v && !g_id) pend0 = 0;
            if (g_v && g_id)  pend1 = 0;
        end
        rst = 0; req0 = 0; req1 = 0;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
